// File: rtl/morse_pkg.sv
// morse_pkg: shared Morse symbol constants, timing multipliers and keyer states
package morse_pkg;
  localparam logic [1:0] SYM_DOT = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_EMPTY = 2'b11;
  localparam logic [9:0] SEQ_EMPTY = 10'h3FF;
  localparam int DOT_UNITS = 1;
  localparam int DASH_UNITS = 3;
  localparam int SYM_GAP_UNITS = 1;
  localparam int CHAR_GAP_UNITS = 3;
  typedef enum logic [2:0] {IDLE, ENCODE, KEY, GAP, DONE} state_e;
  function automatic logic [1:0] char_of(input logic [3:0] p);
    return p >= 4'd10 ? 2'd2 : p >= 4'd5 ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/ascii_to_sequence.sv
// ascii_to_sequence: combinational ASCII byte to 10-bit Morse sequence with unsupported flag
module ascii_to_sequence
  import morse_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [9:0] seq,
  output logic       unsupported
);
  logic [7:0] up;
  assign up = (ascii >= 8'h61 && ascii <= 8'h7A) ? ascii - 8'h20 : ascii;
  assign unsupported = seq == SEQ_EMPTY && ascii != 8'h00;
  always_comb begin
    case (up)
      "A": seq = 10'b0001111111;
      "B": seq = 10'b0100000011;
      "C": seq = 10'b0100010011;
      "D": seq = 10'b0100001111;
      "E": seq = 10'b0011111111;
      "F": seq = 10'b0000010011;
      "G": seq = 10'b0101001111;
      "H": seq = 10'b0000000011;
      "I": seq = 10'b0000111111;
      "J": seq = 10'b0001010111;
      "K": seq = 10'b0100011111;
      "L": seq = 10'b0001000011;
      "M": seq = 10'b0101111111;
      "N": seq = 10'b0100111111;
      "O": seq = 10'b0101011111;
      "P": seq = 10'b0001010011;
      "Q": seq = 10'b0101000111;
      "R": seq = 10'b0001001111;
      "S": seq = 10'b0000001111;
      "T": seq = 10'b0111111111;
      "U": seq = 10'b0000011111;
      "V": seq = 10'b0000000111;
      "W": seq = 10'b0001011111;
      "X": seq = 10'b0100000111;
      "Y": seq = 10'b0100010111;
      "Z": seq = 10'b0101000011;
      "0": seq = 10'b0101010101;
      "1": seq = 10'b0001010101;
      "2": seq = 10'b0000010101;
      "3": seq = 10'b0000000101;
      "4": seq = 10'b0000000001;
      "5": seq = 10'b0000000000;
      "6": seq = 10'b0100000000;
      "7": seq = 10'b0101000000;
      "8": seq = 10'b0101010000;
      "9": seq = 10'b0101010100;
      default: seq = SEQ_EMPTY;
    endcase
  end
endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: encodes three ASCII characters and keys them out with Morse timing
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] characters,
  input  logic        load,
  output logic        ready,
  output logic        busy,
  output logic        key_out,
  output logic [29:0] sequences,
  output logic        done,
  output logic        invalid
);
  localparam int CW = $clog2(3 * UNIT_CYCLES);
  localparam logic [CW-1:0] DOT_LEN = CW'(DOT_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] DASH_LEN = CW'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] SGAP_LEN = CW'(SYM_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CGAP_LEN = CW'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, sym_len, gap_len;
  logic [3:0] pos_q, pos_d, nxt, start;
  logic [29:0] seq_q, seq_d, enc;
  logic [2:0] bad;
  logic inv_q, inv_d, key_q, key_d, found;
  logic [1:0] syms [15];
  for (genvar i = 0; i < 3; i++) begin : g_enc
    ascii_to_sequence u_enc (
      .ascii      (characters[23-8*i -: 8]),
      .seq        (enc[29-10*i -: 10]),
      .unsupported(bad[2-i])
    );
  end
  for (genvar i = 0; i < 15; i++) begin : g_sym
    assign syms[i] = seq_q[29-2*i -: 2];
  end
  always_comb begin
    start = state_q == ENCODE ? 4'd0 : pos_q + 4'd1;
    nxt = 4'd0;
    found = 1'b0;
    for (int j = 14; j >= 0; j--) begin
      if (4'(j) >= start && syms[j] != SYM_EMPTY) begin
        nxt = 4'(j);
        found = 1'b1;
      end
    end
    sym_len = syms[nxt] == SYM_DASH ? DASH_LEN : DOT_LEN;
    gap_len = char_of(nxt) == char_of(pos_q) ? SGAP_LEN : CGAP_LEN;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pos_d = pos_q;
    seq_d = seq_q;
    inv_d = inv_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = load ? ENCODE : IDLE;
        seq_d = load ? enc : seq_q;
        inv_d = load ? |bad : inv_q;
      end
      ENCODE: begin
        state_d = found ? KEY : DONE;
        pos_d = nxt;
        cnt_d = sym_len;
      end
      KEY: begin
        state_d = cnt_q != '0 ? KEY : found ? GAP : DONE;
        cnt_d = cnt_q != '0 ? cnt_q - 1'b1 : gap_len;
      end
      GAP: begin
        state_d = cnt_q != '0 ? GAP : KEY;
        cnt_d = cnt_q != '0 ? cnt_q - 1'b1 : sym_len;
        pos_d = cnt_q != '0 ? pos_q : nxt;
      end
      default: state_d = IDLE;
    endcase
    key_d = state_d == KEY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pos_q <= '0;
      seq_q <= '1;
      inv_q <= 1'b0;
      key_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      seq_q <= seq_d;
      inv_q <= inv_d;
      key_q <= key_d;
    end
  end
  assign busy = state_q == ENCODE || state_q == KEY || state_q == GAP;
  assign ready = ~busy;
  assign done = state_q == DONE;
  assign key_out = key_q;
  assign sequences = seq_q;
  assign invalid = inv_q;
endmodule

// File: doc/morse_keyer.md
# morse_keyer

Transmit-side counterpart of the Morse sequence translator. It accepts three ASCII characters and encodes each into the team's 10-bit Morse sequence format, then drives a single key line with standard Morse timing. The key line feeds the LED/buzzer driver, which closes the loop with the receive path.

## Interface
- UNIT_CYCLES, 25_000_000, clock cycles per Morse time unit (≥2)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- characters  in  24  three ASCII bytes; [23:16] is sent first, [7:0] last
- load  in  1  start request; sampled only while ready=1
- ready  out  1  high when idle and able to accept load; equals ~busy
- busy  out  1  high from the cycle after load is accepted until done
- key_out  out  1  Morse key line, registered; 1 = tone/light on
- sequences  out  30  encoded sequences, registered at load; [29:20] is char 0
- done  out  1  one-cycle pulse at end of transmission
- invalid  out  1  sticky; set when any byte is unsupported; cleared on next accepted load

## Operation
- Sequence format: five 2-bit symbols, MSB pair first. 00 = dot, 01 = dash, 11 = empty (pad). 10 is never produced. Symbols are left-aligned and padded with 11.
- Encoding: A–Z (0x41–0x5A) and a–z (0x61–0x7A) use the same international code. Digits 0–9 use the 5-symbol codes.
  - 0x00 (null) maps to 10'h3FF. It is not flagged.
  - Any other byte maps to 10'h3FF and sets invalid.
- Element timing in units:
  - dot is high 1 unit; dash is high 3 units
  - gap between symbols in a character is 1 unit low
  - gap between non-empty characters is 3 units low
- Empty characters (10'h3FF) are skipped entirely and add no gap. There is no leading gap and no trailing gap.
- FSM states: IDLE, ENCODE, KEY, GAP, DONE.
  - IDLE: on load, register sequences, clear and then update invalid, and go to ENCODE.
  - ENCODE: select the first non-empty symbol. If one exists, go to KEY. If none, go to DONE.
  - KEY: key_out=1 for 1×UNIT_CYCLES (dot) or 3×UNIT_CYCLES (dash).
    - If another symbol follows, go to GAP with length 1 unit (same character) or 3 units (next non-empty character).
    - If no symbol follows, go to DONE.
  - GAP: key_out=0 for its loaded length, then go to KEY for the next symbol. No idle cycles are inserted.
  - DONE: done=1 and busy=0 for one cycle, then IDLE. A load in this cycle is accepted.
- A load while busy is ignored. characters is not re-sampled during a transmission.
- Duration counter is sized to $clog2(3*UNIT_CYCLES) bits and counts down. The counter and symbol pointer (char 0–2, symbol 0–4) reload on every state entry.

## Timing
- Reset values: key_out=0, busy=0, done=0, invalid=0, sequences=30'h3FFFFFFF, state IDLE. ready=1 from the first cycle after reset.
- Reset mid-transmission: on the next edge, key_out=0, all outputs return to reset values, and no done pulse is issued.
- Latency from load acceptance:
  - load is sampled at edge E; sequences, invalid and busy are valid after E.
  - key_out first goes high after edge E+1.
- Each key_out high period and each low gap is exactly N×UNIT_CYCLES consecutive cycles, with no extra cycles between elements.
- done is high the cycle immediately after the last key_out-high cycle, or 2 cycles after load for an all-empty input.

## Structure
- Shared package morse_pkg holds:
  - symbol constants SYM_DOT=2'b00, SYM_DASH=2'b01, SYM_EMPTY=2'b11
  - SEQ_EMPTY=10'h3FF
  - unit multipliers DOT_UNITS=1, DASH_UNITS=3, SYM_GAP_UNITS=1, CHAR_GAP_UNITS=3
  - the state enum
- Sub-module ascii_to_sequence: combinational byte → {sequence[9:0], unsupported}. It is instantiated three times and is reusable by the receive path's test benches.

## Test plan
All scenarios use UNIT_CYCLES=4.
- "SOS" 0x534F53 → sequences={0000001111,0101011111,0000001111}; key pattern high 4/low 4 ×3, low 12, high 12/low 4 ×3, low 12, 4/4 ×3. Last high is followed by done; total 108 cycles from first high to done; invalid=0.
- 0x530053 → middle sequence 10'h3FF; S, 12-cycle gap, S; invalid=0.
- 0x234F00 ('#','O',null) → invalid=1; only O keyed (12/4/12/4/12); key_out first high 2 cycles after load.
- 0x000000 → no key_out activity; done pulses 2 cycles after load. A second load during an earlier busy transmission is ignored, checked by an unchanged sequences value.
- rst asserted mid-dash → key_out=0 and busy=0 after that edge; a load on the next cycle is accepted and the transmission restarts cleanly.
- 'e' 0x650000 vs 'E' 0x450000 → identical output: sequences[29:20]=0011111111, a single 4-cycle high, then done.
